fsm_pattern_tx: RTL and testbench

//  Serial bit-pattern transmitter. Accepts a parallel pattern word over a valid/ready load

---
 rtl/fsm_pattern_tx.sv | 152 +++++++++++++++
 tb/tb_fsm_pattern_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_pattern_tx.sv
// Serial pattern transmitter: loads a parallel word and shifts it out
// MSB-first, with repeat count, abort and optional inter-frame gap.
module fsm_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 4,
  parameter int RPT_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [RPT_W-1:0] load_repeat,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [IW-1:0]    IDX_ONE = IW'(1);
  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);
  localparam logic [GW-1:0]    GAP_ONE = GW'(1);
  localparam logic [GW-1:0]    GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]       state;
  logic [WIDTH-1:0] data;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    idx;
  logic [RPT_W-1:0] rpt;
  logic [GW-1:0]    gap_cnt;

  logic             accept;
  logic [LEN_W-1:0] len_c;
  logic [IW-1:0]    first_idx;
  logic [IW-1:0]    dec_idx;
  logic             last_bit;

  // abort outranks a simultaneous load request
  assign accept = (state == S_IDLE) && load_valid && !abort;

  always_comb begin
    len_c = load_len;
    if (load_len > LEN_MAX) begin
      len_c = LEN_MAX;
    end
  end

  assign first_idx = IW'(len_c - LEN_ONE);
  assign dec_idx   = idx - IDX_ONE;
  assign last_bit  = (idx == '0) && (rpt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      data       <= '0;
      top_idx    <= '0;
      idx        <= '0;
      rpt        <= '0;
      gap_cnt    <= '0;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            data <= load_data;
            rpt  <= load_repeat;
            if (load_len == '0) begin
              done <= 1'b1;
            end else begin
              top_idx    <= first_idx;
              idx        <= first_idx;
              out        <= load_data[first_idx];
              out_valid  <= 1'b1;
              busy       <= 1'b1;
              load_ready <= 1'b0;
              state      <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state      <= S_IDLE;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else if (last_bit) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              load_ready <= 1'b1;
              done       <= 1'b1;
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_LAST;
            end
          end else if (idx == '0) begin
            // next repetition starts on the very next cycle
            idx <= top_idx;
            rpt <= rpt - RPT_ONE;
            out <= data[top_idx];
          end else begin
            idx <= dec_idx;
            out <= data[dec_idx];
          end
        end
        S_GAP: begin
          if (abort) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else if (gap_cnt == '0) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            load_ready <= 1'b1;
            done       <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: begin
          state      <= S_IDLE;
          out        <= 1'b0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_pattern_tx.sv
// Directed bench for fsm_pattern_tx: one DUT without gap, one with a
// two-cycle gap, both driven by the same stimulus.
module tb_fsm_pattern_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic [3:0] load_len = '0;
  logic [3:0] load_repeat = '0;
  logic       abort = 1'b0;

  logic rdy0, out0, ov0, busy0, done0;
  logic rdy2, out2, ov2, busy2, done2;

  int checks = 0;
  int errors = 0;

  logic [63:0] bits;
  int          n;

  always #5 clk = ~clk;

  fsm_pattern_tx #(.WIDTH(8), .LEN_W(4), .RPT_W(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy0),
    .load_data(load_data), .load_len(load_len), .load_repeat(load_repeat),
    .abort(abort), .out(out0), .out_valid(ov0), .busy(busy0), .done(done0)
  );

  fsm_pattern_tx #(.WIDTH(8), .LEN_W(4), .RPT_W(4), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy2),
    .load_data(load_data), .load_len(load_len), .load_repeat(load_repeat),
    .abort(abort), .out(out2), .out_valid(ov2), .busy(busy2), .done(done2)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] d, input logic [3:0] len,
                      input logic [3:0] rpt);
    load_data   = d;
    load_len    = len;
    load_repeat = rpt;
    load_valid  = 1'b1;
    cyc();
    load_valid  = 1'b0;
  endtask

  // collect dut0 bits while out_valid is high, bounded
  task automatic capture(output logic [63:0] b, output int cnt);
    b   = '0;
    cnt = 0;
    while (ov0 && cnt < 200) begin
      b = {b[62:0], out0};
      cnt++;
      cyc();
    end
  endtask

  // reference "110" detector over the captured stream
  function automatic int det110(input logic [63:0] b, input int cnt);
    int hits = 0;
    for (int i = cnt - 1; i >= 2; i--) begin
      if (b[i] && b[i-1] && !b[i-2]) hits++;
    end
    return hits;
  endfunction

  initial begin
    // reset state
    cyc();
    cyc();
    chk("rst_ready", 64'(rdy0), 64'd1);
    chk("rst_ov", 64'(ov0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_out", 64'(out0), 64'd0);
    reset = 1'b1;
    cyc();

    // single 110 frame
    load(8'h06, 4'd3, 4'd0);
    chk("t1_busy", 64'(busy0), 64'd1);
    chk("t1_ready", 64'(rdy0), 64'd0);
    capture(bits, n);
    chk("t1_len", 64'(n), 64'd3);
    chk("t1_bits", bits, 64'b110);
    chk("t1_det", 64'(det110(bits, n)), 64'd1);
    chk("t1_done", 64'(done0), 64'd1);
    chk("t1_out0", 64'(out0), 64'd0);
    cyc();
    chk("t1_done_clr", 64'(done0), 64'd0);
    cyc();
    cyc();
    cyc();

    // three repetitions, contiguous
    load(8'b110, 4'd3, 4'd2);
    capture(bits, n);
    chk("t2_len", 64'(n), 64'd9);
    chk("t2_bits", bits, 64'b110110110);
    chk("t2_det", 64'(det110(bits, n)), 64'd3);
    chk("t2_done", 64'(done0), 64'd1);
    cyc();
    chk("t2_done_clr", 64'(done0), 64'd0);
    cyc();
    cyc();
    cyc();

    // zero length
    load(8'hFF, 4'd0, 4'd0);
    chk("t3_ov", 64'(ov0), 64'd0);
    chk("t3_done", 64'(done0), 64'd1);
    chk("t3_ready", 64'(rdy0), 64'd1);
    chk("t3_busy", 64'(busy0), 64'd0);
    cyc();
    chk("t3_done_clr", 64'(done0), 64'd0);
    cyc();
    cyc();
    cyc();

    // over-long length clamps to 8
    load(8'hA5, 4'd12, 4'd0);
    capture(bits, n);
    chk("t3_clamp_len", 64'(n), 64'd8);
    chk("t3_clamp_bits", bits, 64'hA5);
    chk("t3_clamp_done", 64'(done0), 64'd1);
    cyc();
    cyc();
    cyc();

    // back-to-back loads held valid; gap on dut2
    load_data   = 8'h02;
    load_len    = 4'd2;
    load_repeat = 4'd0;
    load_valid  = 1'b1;
    cyc();
    chk("t4_k1_ov2", 64'({ov2, out2}), 64'b11);
    chk("t4_k1_ov0", 64'({ov0, out0}), 64'b11);
    cyc();
    chk("t4_k2_ov2", 64'({ov2, out2}), 64'b10);
    cyc();
    chk("t4_k3_gap", 64'({ov2, out2, busy2, rdy2}), 64'b0010);
    chk("t4_k3_d0", 64'({done0, rdy0}), 64'b11);
    cyc();
    chk("t4_k4_gap", 64'({ov2, out2, busy2, rdy2}), 64'b0010);
    chk("t4_k4_ov0", 64'({ov0, out0}), 64'b11);
    cyc();
    chk("t4_k5_idle", 64'({done2, rdy2, busy2, ov2}), 64'b1100);
    cyc();
    chk("t4_k6_ov2", 64'({ov2, out2}), 64'b11);
    chk("t4_k6_d0", 64'({done0, ov0}), 64'b10);
    load_valid = 1'b0;
    cyc();
    chk("t4_k7_ov2", 64'({ov2, out2}), 64'b10);
    chk("t4_k7_d0", 64'({done0, ov0, rdy0}), 64'b001);
    cyc();
    chk("t4_k8_gap", 64'({ov2, busy2, rdy2, done2}), 64'b0100);
    cyc();
    chk("t4_k9_gap", 64'({ov2, busy2, rdy2, done2}), 64'b0100);
    cyc();
    chk("t4_k10_done", 64'({done2, rdy2, busy2}), 64'b110);
    cyc();
    chk("t4_k11_clr", 64'(done2), 64'd0);
    cyc();

    // abort on the second bit
    load(8'hFF, 4'd8, 4'd0);
    chk("t5_bit1", 64'({ov0, out0}), 64'b11);
    cyc();
    chk("t5_bit2", 64'({ov0, out0}), 64'b11);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5_ab0", 64'({ov0, out0, busy0, rdy0, done0}), 64'b00010);
    chk("t5_ab2", 64'({ov2, busy2, rdy2, done2}), 64'b0010);
    cyc();
    chk("t5_nodone", 64'({done0, done2, ov0}), 64'b000);
    cyc();

    // abort with load in IDLE: load rejected
    load_data   = 8'h06;
    load_len    = 4'd3;
    load_valid  = 1'b1;
    abort       = 1'b1;
    cyc();
    load_valid  = 1'b0;
    abort       = 1'b0;
    chk("t5_rej", 64'({ov0, busy0, rdy0, done0}), 64'b0010);
    cyc();
    chk("t5_rej2", 64'({ov0, busy0, done0}), 64'b000);

    // asynchronous reset mid-frame
    load(8'hFF, 4'd8, 4'd1);
    cyc();
    chk("t6_pre", 64'({ov0, busy0}), 64'b11);
    #1 reset = 1'b0;
    #1;
    chk("t6_async", 64'({ov0, out0, busy0, rdy0, done0}), 64'b00010);
    chk("t6_async2", 64'({ov2, busy2, rdy2}), 64'b001);
    cyc();
    reset = 1'b1;
    cyc();
    chk("t6_idle", 64'({done0, ov0, rdy0}), 64'b001);
    load(8'h06, 4'd3, 4'd0);
    capture(bits, n);
    chk("t6_len", 64'(n), 64'd3);
    chk("t6_bits", bits, 64'b110);
    chk("t6_done", 64'(done0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
